// File: rtl/reg_file_wdemux_pkg.sv
// reg_file_wdemux_pkg: shared sizing constants for the register bank and its write decoder
package reg_file_wdemux_pkg;
    localparam int          REG_COUNT    = 16;
    localparam logic [3:0]  PC_INDEX     = 4'd15;
    localparam int          WCOUNT_WIDTH = 16;
endpackage

// File: rtl/decoder_4to16.sv
// decoder_4to16: write-side demux turning a register index into a one-hot write strobe
module decoder_4to16
    import reg_file_wdemux_pkg::*;
(
    input  logic [3:0]           addr,
    input  logic                 enable,
    output logic [REG_COUNT-1:0] onehot
);
    // the PC slot is never strobed, so writes to it vanish here
    assign onehot = (enable && addr != PC_INDEX) ? REG_COUNT'(1) << addr : '0;
endmodule

// File: rtl/reg_file_wdemux.sv
// reg_file_wdemux: 15 stored registers plus PC-backed R15, one decoded write port, three read ports
module reg_file_wdemux
    import reg_file_wdemux_pkg::*;
#(
    parameter int data_width = 32,
    parameter int addr_width = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_enable,
    input  logic [addr_width-1:0]   write_addr,
    input  logic [data_width-1:0]   write_data,
    input  logic [addr_width-1:0]   read_addr1,
    input  logic [addr_width-1:0]   read_addr2,
    input  logic [addr_width-1:0]   debug_addr,
    input  logic [data_width-1:0]   r15_in,
    output logic [data_width-1:0]   read_data1,
    output logic [data_width-1:0]   read_data2,
    output logic [data_width-1:0]   debug_data,
    output logic [WCOUNT_WIDTH-1:0] write_count
);
    logic [data_width-1:0] regs [0:REG_COUNT-2];
    logic [REG_COUNT-1:0]  onehot;

    decoder_4to16 u_dec (
        .addr   (write_addr),
        .enable (write_enable),
        .onehot (onehot)
    );

    // store write_data into the strobed register; reset clears the bank immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT - 1; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT - 1; i++) if (onehot[i]) regs[i] <= write_data;
        end
    end

    // count committed writes; a strobe only exists for non-PC targets, and the count wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) write_count <= '0;
        else if (|onehot) write_count <= write_count + 1'b1;
    end

    // port 1 read mux: PC index comes from outside, no bypass of pending writes
    always_comb begin
        case (read_addr1)
            PC_INDEX: read_data1 = r15_in;
            default:  read_data1 = regs[read_addr1];
        endcase
    end

    // port 2 read mux
    always_comb begin
        case (read_addr2)
            PC_INDEX: read_data2 = r15_in;
            default:  read_data2 = regs[read_addr2];
        endcase
    end

    // debug read mux
    always_comb begin
        case (debug_addr)
            PC_INDEX: debug_data = r15_in;
            default:  debug_data = regs[debug_addr];
        endcase
    end
endmodule

// File: tb/tb_reg_file_wdemux.sv
// tb_reg_file_wdemux: scoreboard bench against an array model of the register bank
module tb_reg_file_wdemux;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_enable = 1'b0;
    logic [3:0]  write_addr = '0;
    logic [31:0] write_data = '0;
    logic [3:0]  read_addr1 = '0;
    logic [3:0]  read_addr2 = '0;
    logic [3:0]  debug_addr = '0;
    logic [31:0] r15_in = '0;
    logic [31:0] read_data1, read_data2, debug_data;
    logic [15:0] write_count;

    reg_file_wdemux dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .debug_addr   (debug_addr),
        .r15_in       (r15_in),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .debug_data   (debug_data),
        .write_count  (write_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t   sb[$];
    logic [31:0] model [16];
    int          wcount = 0;
    int          passed = 0;
    int          total  = 0;

    function automatic logic [31:0] ref_read(input logic [3:0] a, input logic [31:0] r15);
        return (a == 4'd15) ? r15 : model[a];
    endfunction

    task automatic push(input int port, input logic [31:0] exp, input string name);
        sb_entry_t e;
        e.port = port;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input logic rst_v, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] ad,
                        input logic [31:0] r15, input string tag);
        @(posedge clk);
        #1;
        reset = rst_v;
        write_enable = we;
        write_addr = wa;
        write_data = wd;
        read_addr1 = a1;
        read_addr2 = a2;
        debug_addr = ad;
        r15_in = r15;
        if (rst_v) begin
            for (int i = 0; i < 16; i++) model[i] = '0;
            wcount = 0;
        end
        push(0, ref_read(a1, r15), {tag, ".rd1"});
        push(1, ref_read(a2, r15), {tag, ".rd2"});
        push(2, ref_read(ad, r15), {tag, ".dbg"});
        push(3, 32'(wcount), {tag, ".wcount"});
        if (!rst_v && we && wa != 4'd15) begin
            model[wa] = wd;
            wcount = (wcount + 1) % 65536;
        end
    endtask

    logic [31:0] act;
    sb_entry_t   cur;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            act = (cur.port == 0) ? read_data1 :
                  (cur.port == 1) ? read_data2 :
                  (cur.port == 2) ? debug_data : {16'h0, write_count};
            total++;
            if (act === cur.exp) passed++;
            else $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $finish;
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = '0;
        step(1, 0, 0, 0, 3, 4, 15, 32'h108, "rst0");
        step(0, 1, 3, 32'hDEADBEEF, 3, 3, 3, 32'h108, "pre3");
        step(0, 0, 0, 0, 3, 0, 3, 32'h108, "chk3");
        step(1, 1, 6, 32'h1111, 3, 6, 3, 32'h108, "rstmid");
        #1;
        total++;
        if (read_data1 === 32'h0 && write_count === 16'h0) passed++;
        else $display("FAIL reset-state: rd1=%h wcount=%h", read_data1, write_count);
        step(0, 1, 5, 32'h12345678, 5, 4, 5, 32'h108, "wr5");
        step(0, 0, 0, 0, 5, 4, 5, 32'h108, "rd5");
        step(0, 1, 15, 32'hFFFFFFFF, 15, 5, 15, 32'h108, "wr15");
        step(0, 0, 0, 0, 15, 5, 0, 32'h108, "rd15");
        step(0, 1, 7, 32'hA, 7, 7, 7, 32'h200, "r7a");
        step(0, 1, 7, 32'hB, 7, 7, 7, 32'h200, "rdw");
        step(0, 0, 0, 0, 7, 7, 7, 32'h200, "r7b");
        step(1, 0, 0, 0, 0, 0, 0, 32'h300, "rst1");
        for (int i = 0; i < 15; i++)
            step(0, 1, 4'(i), 32'(i + 1), 4'(i), 4'(14 - i), 15, 32'h300, "sweep");
        for (int i = 0; i < 15; i++)
            step(0, 0, 0, 0, 4'(i), 4'(14 - i), 4'(i), 32'h300, "sweeprd");
        step(0, 0, 2, 32'h55, 2, 2, 2, 32'h300, "we0");
        step(0, 0, 0, 0, 2, 2, 2, 32'h300, "we0rd");
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 49) == 0, 1'($urandom), 4'($urandom), $urandom,
                 4'($urandom), 4'($urandom), 4'($urandom), $urandom, "rand");
        step(1, 0, 0, 0, 0, 0, 0, 0, "rst2");
        for (int n = 0; n < 65536; n++)
            step(0, 1, 4'($urandom_range(0, 14)), $urandom,
                 4'($urandom), 4'($urandom), 4'($urandom), $urandom, "wrap");
        step(0, 0, 0, 0, 1, 2, 3, 0, "wrapped");
        #1;
        total++;
        if (write_count === 16'h0) passed++;
        else $display("FAIL wrap: write_count=%h expected 0000", write_count);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
